// File: rtl/video_timing_gen.sv
// video_timing_gen: parametrised raster timing generator with RGB565 test
// patterns. A request stage prefetches pixels from an upstream source and a
// REQ_LEAD-deep pipeline realigns sync/enable/pixel with the returned data.
// Handshake: data_req is a one-way strobe with no back-pressure; the source
// must present pixel_data exactly REQ_LEAD-1 cycles after each data_req
// (same cycle when REQ_LEAD=1), and the block never stalls.
module video_timing_gen #(
  parameter int H_SYNC   = 136,
  parameter int H_BACK   = 160,
  parameter int H_DISP   = 1024,
  parameter int H_FRONT  = 24,
  parameter int V_SYNC   = 6,
  parameter int V_BACK   = 29,
  parameter int V_DISP   = 768,
  parameter int V_FRONT  = 3,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int REQ_LEAD = 2,
  parameter int CNT_W    = 12
) (
  input  logic        pixel_clk,
  input  logic        sys_rst_n,
  input  logic        en,
  input  logic [1:0]  mode,
  input  logic [15:0] pixel_data,
  output logic        data_req,
  output logic [10:0] pixel_xpos,
  output logic [10:0] pixel_ypos,
  output logic        frame_start,
  output logic [10:0] h_disp,
  output logic [10:0] v_disp,
  output logic        video_hs,
  output logic        video_vs,
  output logic        video_de,
  output logic [15:0] video_rgb
);

  localparam int H_TOTAL = H_SYNC + H_BACK + H_DISP + H_FRONT;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_DISP + V_FRONT;
  localparam int LS      = REQ_LEAD - 1;  // stage feeding the rgb register

  localparam logic [CNT_W-1:0] C_H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] C_V_LAST = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] C_HA     = CNT_W'(H_SYNC + H_BACK);
  localparam logic [CNT_W-1:0] C_HA_END = CNT_W'(H_SYNC + H_BACK + H_DISP);
  localparam logic [CNT_W-1:0] C_VA     = CNT_W'(V_SYNC + V_BACK);
  localparam logic [CNT_W-1:0] C_VA_END = CNT_W'(V_SYNC + V_BACK + V_DISP);
  localparam logic [CNT_W-1:0] C_HSYNC  = CNT_W'(H_SYNC);
  localparam logic [CNT_W-1:0] C_VSYNC  = CNT_W'(V_SYNC);
  localparam logic [10:0]      C_BAR_W  = 11'(H_DISP / 8);
  localparam logic [10:0]      C_X_LAST = 11'(H_DISP - 1);
  localparam logic [10:0]      C_Y_LAST = 11'(V_DISP - 1);

  typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_run;
  logic             w_frame_wrap;
  logic [CNT_W-1:0] r_cnt_h;
  logic [CNT_W-1:0] r_cnt_v;

  logic             w_act;
  logic             w_fs;
  logic             w_hs_on;
  logic             w_vs_on;
  logic [10:0]      w_x;
  logic [10:0]      w_y;

  // Stage 0 is the request stage; stage REQ_LEAD drives the video outputs.
  logic             r_p_act [0:REQ_LEAD];
  logic             r_p_hs  [0:REQ_LEAD];
  logic             r_p_vs  [0:REQ_LEAD];
  logic [10:0]      r_p_x   [0:REQ_LEAD-1];
  logic [10:0]      r_p_y   [0:REQ_LEAD-1];
  logic [1:0]       r_p_md  [0:REQ_LEAD-1];  // r_p_md[0] is the frame mode latch
  logic             r_fs;
  logic [15:0]      r_rgb;

  logic [2:0]       w_bar;
  logic [15:0]      w_bar_rgb;
  logic [15:0]      w_pix;
  logic [10:0]      w_xo;
  logic [10:0]      w_yo;

  assign w_frame_wrap = (r_cnt_h == C_H_LAST) && (r_cnt_v == C_V_LAST);

  // FSM state register
  always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) r_state <= ST_IDLE;
    else            r_state <= w_state_nxt;
  end

  // FSM next state: leave RUN only at the frame wrap so a frame always completes
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (en) w_state_nxt = ST_RUN;
      ST_RUN:  if (w_frame_wrap && !en) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // FSM output decode
  always_comb begin
    w_run = 1'b0;
    if (r_state == ST_RUN) w_run = 1'b1;
  end

  // Raster counters: held at origin while idle, so RUN starts from (0,0)
  always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_cnt_h <= '0;
      r_cnt_v <= '0;
    end else if (!w_run) begin
      r_cnt_h <= '0;
      r_cnt_v <= '0;
    end else if (r_cnt_h == C_H_LAST) begin
      r_cnt_h <= '0;
      r_cnt_v <= (r_cnt_v == C_V_LAST) ? '0 : r_cnt_v + CNT_W'(1);
    end else begin
      r_cnt_h <= r_cnt_h + CNT_W'(1);
    end
  end

  // Request-stage decode of the current raster position
  always_comb begin
    w_act   = w_run && (r_cnt_h >= C_HA) && (r_cnt_h < C_HA_END) &&
              (r_cnt_v >= C_VA) && (r_cnt_v < C_VA_END);
    w_fs    = w_run && (r_cnt_h == '0) && (r_cnt_v == '0);
    w_hs_on = w_run && (r_cnt_h < C_HSYNC);
    w_vs_on = w_run && (r_cnt_v < C_VSYNC);
    w_x     = '0;
    w_y     = '0;
    if (w_act) begin
      w_x = 11'(r_cnt_h - C_HA);
      w_y = 11'(r_cnt_v - C_VA);
    end
  end

  // Request stage plus the alignment pipeline; mode is latched only at frame start
  always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_fs <= 1'b0;
      for (int i = 0; i <= REQ_LEAD; i++) begin
        r_p_act[i] <= 1'b0;
        r_p_hs[i]  <= 1'b0;
        r_p_vs[i]  <= 1'b0;
      end
      for (int i = 0; i < REQ_LEAD; i++) begin
        r_p_x[i]  <= '0;
        r_p_y[i]  <= '0;
        r_p_md[i] <= '0;
      end
    end else begin
      r_fs       <= w_fs;
      r_p_act[0] <= w_act;
      r_p_hs[0]  <= w_hs_on;
      r_p_vs[0]  <= w_vs_on;
      r_p_x[0]   <= w_x;
      r_p_y[0]   <= w_y;
      if (w_fs) r_p_md[0] <= mode;
      for (int i = 1; i <= REQ_LEAD; i++) begin
        r_p_act[i] <= r_p_act[i-1];
        r_p_hs[i]  <= r_p_hs[i-1];
        r_p_vs[i]  <= r_p_vs[i-1];
      end
      for (int i = 1; i < REQ_LEAD; i++) begin
        r_p_x[i]  <= r_p_x[i-1];
        r_p_y[i]  <= r_p_y[i-1];
        r_p_md[i] <= r_p_md[i-1];
      end
    end
  end

  assign w_xo  = r_p_x[LS];
  assign w_yo  = r_p_y[LS];
  assign w_bar = 3'(w_xo / C_BAR_W);

  // Colour-bar lookup, left to right
  always_comb begin
    w_bar_rgb = 16'h0000;
    case (w_bar)
      3'd0: w_bar_rgb = 16'hFFFF;
      3'd1: w_bar_rgb = 16'hFFE0;
      3'd2: w_bar_rgb = 16'h07FF;
      3'd3: w_bar_rgb = 16'h07E0;
      3'd4: w_bar_rgb = 16'hF81F;
      3'd5: w_bar_rgb = 16'hF800;
      3'd6: w_bar_rgb = 16'h001F;
      default: w_bar_rgb = 16'h0000;
    endcase
  end

  // Pixel source select by the frame's latched mode
  always_comb begin
    w_pix = pixel_data;
    case (r_p_md[LS])
      2'd0: w_pix = pixel_data;
      2'd1: w_pix = w_bar_rgb;
      2'd2: w_pix = ((w_xo[4:0] == 5'd0) || (w_yo[4:0] == 5'd0) ||
                     (w_xo == C_X_LAST) || (w_yo == C_Y_LAST)) ? 16'hFFFF : 16'h0000;
      default: w_pix = {w_xo[7:3], w_yo[7:2], w_xo[7:3]};
    endcase
  end

  // Output pixel register, blanked outside the active area
  always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)        r_rgb <= '0;
    else if (r_p_act[LS])  r_rgb <= w_pix;
    else                   r_rgb <= '0;
  end

  assign data_req    = r_p_act[0];
  assign pixel_xpos  = r_p_x[0];
  assign pixel_ypos  = r_p_y[0];
  assign frame_start = r_fs;
  assign h_disp      = 11'(H_DISP);
  assign v_disp      = 11'(V_DISP);
  assign video_de    = r_p_act[REQ_LEAD];
  assign video_hs    = r_p_hs[REQ_LEAD] ? HS_POL : ~HS_POL;
  assign video_vs    = r_p_vs[REQ_LEAD] ? VS_POL : ~VS_POL;
  assign video_rgb   = r_rgb;

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: four configurations (REQ_LEAD 1..4, two sizes,
// both sync polarities) share random en/mode/reset stimulus and are compared
// every cycle against a frame-index reference model.
module tb_video_timing_gen;

  typedef struct {
    logic run;
    int   h;
    int   v;
    int   md;
  } rec_t;

  logic       clk = 1'b0;
  logic       sys_rst_n = 1'b1;
  logic       en = 1'b0;
  logic [1:0] mode = 2'd0;

  int n_checks = 0;
  int n_fail   = 0;

  // clock / reset block
  always #5 clk = ~clk;

  task automatic check_val(input int u, input string tag,
                           input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL u%0d %s got=%0h exp=%0h t=%0t", u, tag, got, exp, $time);
    end
  endtask

  // Upstream source content for a requested pixel
  function automatic logic [15:0] src_pix(input logic [10:0] x, input logic [10:0] y);
    return {y[4:0], x} ^ 16'hA5C3;
  endfunction

  // Expected on-screen pixel from the pattern rules
  function automatic logic [15:0] exp_pixel(input int md, input int x, input int y,
                                            input int hd, input int vd);
    case (md)
      0: return src_pix(11'(x), 11'(y));
      1: begin
        case (x / (hd / 8))
          0: return 16'hFFFF;
          1: return 16'hFFE0;
          2: return 16'h07FF;
          3: return 16'h07E0;
          4: return 16'hF81F;
          5: return 16'hF800;
          6: return 16'h001F;
          default: return 16'h0000;
        endcase
      end
      2: return ((x % 32 == 0) || (y % 32 == 0) || (x == hd - 1) || (y == vd - 1))
                ? 16'hFFFF : 16'h0000;
      default: return {5'((x / 8) % 32), 6'((y / 4) % 64), 5'((x / 8) % 32)};
    endcase
  endfunction

  for (genvar g = 0; g < 4; g++) begin : g_u
    localparam int HS = 4, HB = 4, HF = 4, VS = 2, VB = 2, VF = 2;
    localparam int HD = (g == 1) ? 64 : 16;
    localparam int VD = (g == 1) ? 16 : 8;
    localparam int HT = HS + HB + HD + HF;
    localparam int VT = VS + VB + VD + VF;
    localparam int HA = HS + HB;
    localparam int VA = VS + VB;
    localparam bit HP = (g == 1) ? 1'b0 : 1'b1;
    localparam bit VP = (g == 1) ? 1'b1 : 1'b0;
    localparam int L  = (g == 0) ? 2 : (g == 1) ? 3 : (g == 2) ? 1 : 4;

    logic        data_req, frame_start, video_hs, video_vs, video_de;
    logic [10:0] pixel_xpos, pixel_ypos, h_disp, v_disp;
    logic [15:0] pixel_data, video_rgb;

    video_timing_gen #(
      .H_SYNC(HS), .H_BACK(HB), .H_DISP(HD), .H_FRONT(HF),
      .V_SYNC(VS), .V_BACK(VB), .V_DISP(VD), .V_FRONT(VF),
      .HS_POL(HP), .VS_POL(VP), .REQ_LEAD(L), .CNT_W(12)
    ) u_dut (
      .pixel_clk(clk), .sys_rst_n(sys_rst_n), .en(en), .mode(mode),
      .pixel_data(pixel_data), .data_req(data_req), .pixel_xpos(pixel_xpos),
      .pixel_ypos(pixel_ypos), .frame_start(frame_start), .h_disp(h_disp),
      .v_disp(v_disp), .video_hs(video_hs), .video_vs(video_vs),
      .video_de(video_de), .video_rgb(video_rgb)
    );

    // Pixel source honouring the REQ_LEAD-1 return latency
    if (L == 1) begin : g_src_comb
      assign pixel_data = src_pix(pixel_xpos, pixel_ypos);
    end else begin : g_src_reg
      logic [15:0] sq [L-1];
      always @(posedge clk) begin
        sq[0] <= src_pix(pixel_xpos, pixel_ypos);
        for (int i = 1; i < L - 1; i++) sq[i] <= sq[i-1];
      end
      assign pixel_data = sq[L-2];
    end

    // Reference model: run flag plus a cycle index within the frame.
    // hist[L] is the position registered on the last edge, hist[0] the one
    // L edges earlier (what the video outputs must now show).
    rec_t hist[$];
    rec_t idle_rec;
    logic m_run;
    int   m_n;
    int   m_md;

    task automatic model_reset();
      m_run = 1'b0;
      m_n   = 0;
      m_md  = 0;
      hist.delete();
      for (int i = 0; i <= L; i++) hist.push_back(idle_rec);
    endtask

    initial begin
      idle_rec = '{run: 1'b0, h: 0, v: 0, md: 0};
      model_reset();
      forever begin
        @(posedge clk or negedge sys_rst_n);
        if (!sys_rst_n) begin
          model_reset();
        end else begin
          rec_t r;
          r.run = m_run;
          r.h   = m_n % HT;
          r.v   = m_n / HT;
          if (m_run && m_n == 0) m_md = int'(mode);
          r.md  = m_md;
          hist.push_back(r);
          if (hist.size() > L + 1) void'(hist.pop_front());
          if (!m_run) begin
            if (en) begin
              m_run = 1'b1;
              m_n   = 0;
            end
          end else if (m_n == HT * VT - 1) begin
            m_n = 0;
            if (!en) m_run = 1'b0;
          end else begin
            m_n++;
          end
        end
      end
    end

    // Scoreboard: compare every output on the falling edge
    initial begin
      forever begin
        rec_t q, d;
        logic q_act, d_act;
        @(negedge clk);
        q = hist[L];
        d = hist[0];
        q_act = q.run && q.h >= HA && q.h < HA + HD && q.v >= VA && q.v < VA + VD;
        d_act = d.run && d.h >= HA && d.h < HA + HD && d.v >= VA && d.v < VA + VD;
        check_val(g, "data_req", 32'(data_req), 32'(q_act));
        check_val(g, "xpos", 32'(pixel_xpos), q_act ? 32'(q.h - HA) : 32'd0);
        check_val(g, "ypos", 32'(pixel_ypos), q_act ? 32'(q.v - VA) : 32'd0);
        check_val(g, "frame_start", 32'(frame_start),
                  32'(q.run && q.h == 0 && q.v == 0));
        check_val(g, "video_de", 32'(video_de), 32'(d_act));
        check_val(g, "video_hs", 32'(video_hs), 32'((d.run && d.h < HS) ? HP : !HP));
        check_val(g, "video_vs", 32'(video_vs), 32'((d.run && d.v < VS) ? VP : !VP));
        check_val(g, "video_rgb", 32'(video_rgb),
                  d_act ? 32'(exp_pixel(d.md, d.h - HA, d.v - VA, HD, VD)) : 32'd0);
      end
    end

    // Asynchronous reset must clear outputs within the same cycle
    initial begin
      forever begin
        @(negedge sys_rst_n);
        #1;
        check_val(g, "rst_req", 32'(data_req), 32'd0);
        check_val(g, "rst_fs", 32'(frame_start), 32'd0);
        check_val(g, "rst_xy", 32'({pixel_xpos, pixel_ypos}), 32'd0);
        check_val(g, "rst_de", 32'(video_de), 32'd0);
        check_val(g, "rst_hs", 32'(video_hs), 32'(!HP));
        check_val(g, "rst_vs", 32'(video_vs), 32'(!VP));
        check_val(g, "rst_rgb", 32'(video_rgb), 32'd0);
        check_val(g, "h_disp", 32'(h_disp), 32'(HD));
        check_val(g, "v_disp", 32'(v_disp), 32'(VD));
      end
    end
  end

  // driver: advance n cycles, occasionally changing mode and (optionally) en
  task automatic run_cycles(input int n, input int en_flip_div);
    repeat (n) begin
      @(negedge clk);
      if ($urandom_range(0, 149) == 0) mode = 2'($urandom_range(0, 3));
      if (en_flip_div != 0 && $urandom_range(0, en_flip_div - 1) == 0) en = ~en;
    end
  endtask

  // driver: reset pulse landing mid-cycle
  task automatic reset_pulse();
    @(posedge clk);
    #2 sys_rst_n = 1'b0;
    @(posedge clk);
    #2 sys_rst_n = 1'b1;
  endtask

  initial begin
    #3 sys_rst_n = 1'b0;
    repeat (3) @(negedge clk);
    sys_rst_n = 1'b1;
    run_cycles(5, 0);

    // continuous running with random mode changes
    mode = 2'($urandom_range(0, 3));
    en = 1'b1;
    run_cycles(4000, 0);

    // drop enable mid-frame: frames complete, then idle
    en = 1'b0;
    run_cycles(2000, 0);

    // single-cycle enable pulse gives exactly one frame
    en = 1'b1;
    run_cycles(1, 0);
    en = 1'b0;
    run_cycles(2000, 0);

    // random enable toggling
    run_cycles(8000, 300);

    // reset pulses while running
    en = 1'b1;
    run_cycles($urandom_range(300, 700), 0);
    reset_pulse();
    run_cycles(2500, 0);
    reset_pulse();
    run_cycles(1500, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
